// File: rtl/pred_update_ctrl_pkg.sv
// Shared types and defaults for the branch-resolution predictor update controller.
// Per-record flags are a struct; PC fields stay parameterised in the FIFO payload.
package pred_update_ctrl_pkg;

  localparam int DEF_PC_BITS    = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_BITS   = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic taken;
    logic pred_taken;
    logic is_cf;
    logic is_cond;
    logic is_call;
    logic is_ret;
  } res_flags_t;

  localparam int FLAG_BITS = $bits(res_flags_t);

  // A non-control-flow instruction that was predicted taken also counts as a mispredict.
  function automatic logic is_mispredict(input res_flags_t f, input logic tgt_mismatch);
    if (f.is_cf) begin
      return (f.taken != f.pred_taken) || (f.taken && tgt_mismatch);
    end
    return f.pred_taken;
  endfunction

endpackage

// File: rtl/pred_upd_fifo.sv
// Small synchronous FIFO for resolved-branch records with a whole-queue flush.
// Flush wins over a same-cycle push or pop.
module pred_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pred_update_ctrl.sv
// Buffers resolved branches and replays them one per cycle as registered predictor,
// BTB and RAS updates; a mispredict flushes the queue and idles one DRAIN cycle.
module pred_update_ctrl
  import pred_update_ctrl_pkg::*;
#(
  parameter int PC_BITS    = DEF_PC_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_BITS   = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [PC_BITS-1:0]  res_pc,
  input  logic [PC_BITS-1:0]  res_target,
  input  logic [PC_BITS-1:0]  res_pred_target,
  input  logic                res_taken,
  input  logic                res_pred_taken,
  input  logic                res_is_cf,
  input  logic                res_is_cond,
  input  logic                res_is_call,
  input  logic                res_is_ret,
  output logic                new_entry,
  output logic                is_Taken,
  output logic [PC_BITS-1:0]  PC_Orig,
  output logic [PC_BITS-1:0]  Target_PC,
  output logic                invalidate,
  output logic [PC_BITS-1:0]  old_PC,
  output logic                is_jumpl,
  output logic                is_return,
  output logic                must_flush,
  output logic                branch_resolved,
  output logic [PC_BITS-1:0]  flush_PC,
  output logic [CNT_BITS-1:0] mispredict_cnt
);

  localparam int REC_BITS = 3 * PC_BITS + FLAG_BITS;

  state_e             state_q, state_d;
  logic [REC_BITS-1:0] push_rec, pop_rec;
  res_flags_t         push_flags, pop_flags;
  logic [PC_BITS-1:0] pop_pc, pop_tgt, pop_ptgt;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush, mispred;

  logic                new_entry_q, new_entry_d;
  logic                is_taken_q, is_taken_d;
  logic [PC_BITS-1:0]  pc_orig_q, pc_orig_d;
  logic [PC_BITS-1:0]  target_pc_q, target_pc_d;
  logic                invalidate_q, invalidate_d;
  logic [PC_BITS-1:0]  old_pc_q, old_pc_d;
  logic                is_jumpl_q, is_jumpl_d;
  logic                is_return_q, is_return_d;
  logic                must_flush_q, must_flush_d;
  logic                branch_resolved_q, branch_resolved_d;
  logic [PC_BITS-1:0]  flush_pc_q, flush_pc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // Held low during reset so the producer never sees a ready it cannot use.
  assign res_ready = rst_n & ~fifo_full & (state_q == ST_RUN);
  assign fifo_push = res_valid & res_ready;
  assign fifo_pop  = (state_q == ST_RUN) & ~fifo_empty;

  always_comb begin
    push_flags            = '0;
    push_flags.taken      = res_taken;
    push_flags.pred_taken = res_pred_taken;
    push_flags.is_cf      = res_is_cf;
    push_flags.is_cond    = res_is_cond;
    push_flags.is_call    = res_is_call;
    push_flags.is_ret     = res_is_ret;
  end

  assign push_rec  = {res_pc, res_target, res_pred_target, push_flags};
  assign pop_pc    = pop_rec[REC_BITS-1 -: PC_BITS];
  assign pop_tgt   = pop_rec[REC_BITS-PC_BITS-1 -: PC_BITS];
  assign pop_ptgt  = pop_rec[FLAG_BITS +: PC_BITS];
  assign pop_flags = res_flags_t'(pop_rec[FLAG_BITS-1:0]);
  assign mispred   = is_mispredict(pop_flags, pop_tgt != pop_ptgt);

  pred_upd_fifo #(
    .WIDTH (REC_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .pop_data  (pop_rec),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d           = state_q;
    fifo_flush        = 1'b0;
    cnt_d             = cnt_q;
    new_entry_d       = 1'b0;
    is_taken_d        = 1'b0;
    pc_orig_d         = '0;
    target_pc_d       = '0;
    invalidate_d      = 1'b0;
    old_pc_d          = '0;
    is_jumpl_d        = 1'b0;
    is_return_d       = 1'b0;
    must_flush_d      = 1'b0;
    branch_resolved_d = 1'b0;
    flush_pc_d        = '0;
    case (state_q)
      ST_RUN: begin
        if (fifo_pop) begin
          new_entry_d       = pop_flags.is_cf & (pop_flags.is_cond | pop_flags.taken);
          is_taken_d        = pop_flags.taken;
          pc_orig_d         = pop_pc;
          target_pc_d       = pop_tgt;
          invalidate_d      = ~pop_flags.is_cf & pop_flags.pred_taken;
          old_pc_d          = pop_pc;
          is_jumpl_d        = pop_flags.is_call & pop_flags.is_cf;
          is_return_d       = pop_flags.is_ret & pop_flags.is_cf;
          branch_resolved_d = pop_flags.is_cond;
          if (mispred) begin
            must_flush_d = 1'b1;
            flush_pc_d   = (pop_flags.is_cf & pop_flags.taken) ? pop_tgt : pop_pc + PC_BITS'(4);
            fifo_flush   = 1'b1;
            state_d      = ST_DRAIN;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_RUN;
      cnt_q             <= '0;
      new_entry_q       <= 1'b0;
      is_taken_q        <= 1'b0;
      pc_orig_q         <= '0;
      target_pc_q       <= '0;
      invalidate_q      <= 1'b0;
      old_pc_q          <= '0;
      is_jumpl_q        <= 1'b0;
      is_return_q       <= 1'b0;
      must_flush_q      <= 1'b0;
      branch_resolved_q <= 1'b0;
      flush_pc_q        <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      new_entry_q       <= new_entry_d;
      is_taken_q        <= is_taken_d;
      pc_orig_q         <= pc_orig_d;
      target_pc_q       <= target_pc_d;
      invalidate_q      <= invalidate_d;
      old_pc_q          <= old_pc_d;
      is_jumpl_q        <= is_jumpl_d;
      is_return_q       <= is_return_d;
      must_flush_q      <= must_flush_d;
      branch_resolved_q <= branch_resolved_d;
      flush_pc_q        <= flush_pc_d;
    end
  end

  assign new_entry       = new_entry_q;
  assign is_Taken        = is_taken_q;
  assign PC_Orig         = pc_orig_q;
  assign Target_PC       = target_pc_q;
  assign invalidate      = invalidate_q;
  assign old_PC          = old_pc_q;
  assign is_jumpl        = is_jumpl_q;
  assign is_return       = is_return_q;
  assign must_flush      = must_flush_q;
  assign branch_resolved = branch_resolved_q;
  assign flush_PC        = flush_pc_q;
  assign mispredict_cnt  = cnt_q;

endmodule
